// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared types and constants for the counter sequencing controller.
// The optional prescaler is enabled by the COUNTER_SEQ_PRESCALE_EN macro.
package counter_seq_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // Default counter width
  localparam int CNT_W_DEF = 8;

  // Width of the optional prescale field and its divider
  localparam int PRESC_W = 4;

endpackage : counter_seq_pkg

// File: rtl/tff_chain_counter.sv
// tff_chain_counter: CNT_W toggle flip-flops whose enables are AND-chained,
// so bit i toggles only when T is high and all lower bits are 1.
// clr is synchronous, active-high, and overrides T.
module tff_chain_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             T,
  output logic [CNT_W-1:0] Q
);

  for (genvar i = 0; i < CNT_W; i++) begin : g_stage
    logic en_s;

    if (i == 0) begin : g_first
      assign en_s = T;
    end else begin : g_rest
      assign en_s = g_stage[i-1].en_s & Q[i-1];
    end

    // Toggle flip-flop for bit i
    always_ff @(posedge clk) begin
      if (clr) begin
        Q[i] <= 1'b0;
      end else if (en_s) begin
        Q[i] <= ~Q[i];
      end else begin
        Q[i] <= Q[i];
      end
    end
  end

endmodule : tff_chain_counter

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: start/stop sequencing controller for the TFF chain counter.
// Drives the counter's toggle enable and clear, tracks completed periods and
// pulses done on the cycle after each terminal wrap.
// Optional feature: COUNTER_SEQ_PRESCALE_EN adds a 4-bit tick prescaler.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               stop,
  input  logic               periodic,
  input  logic [CNT_W-1:0]   limit,
`ifdef COUNTER_SEQ_PRESCALE_EN
  input  logic [PRESC_W-1:0] prescale,
`endif
  output logic [CNT_W-1:0]   count,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   periods
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Saturating increment for the period counter
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic             periodic_q, periodic_d;
  logic [CNT_W-1:0] periods_q, periods_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] cnt_s;
  logic             tick_s;
  logic             term_s;
  logic             cnt_clr_s;
  logic             presc_hit_s;

`ifdef COUNTER_SEQ_PRESCALE_EN
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] div_q, div_d;

  assign presc_hit_s = (div_q == presc_q);
`else
  assign presc_hit_s = 1'b1;
`endif

  // Next-state, command decode, and counter control
  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    periodic_d = periodic_q;
    periods_d  = periods_q;
    done_d     = 1'b0;
    tick_s     = 1'b0;
    term_s     = 1'b0;
    cnt_clr_s  = clr;
`ifdef COUNTER_SEQ_PRESCALE_EN
    presc_d    = presc_q;
    div_d      = div_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // stop alone, or stop together with start, leaves us idle
        if (start && !stop) begin
          state_d    = ST_RUN;
          limit_d    = limit;
          periodic_d = periodic;
          periods_d  = '0;
          cnt_clr_s  = 1'b1;
`ifdef COUNTER_SEQ_PRESCALE_EN
          presc_d    = prescale;
          div_d      = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // stop pauses without an increment; a repeated start is ignored
        if (stop) begin
          state_d = ST_PAUSE;
        end else if (presc_hit_s) begin
          tick_s = 1'b1;
`ifdef COUNTER_SEQ_PRESCALE_EN
          div_d  = '0;
`endif
          // limit 0 wraps to all-ones here, giving a 2^CNT_W period
          if (cnt_s == (limit_q - CNT_ONE)) begin
            term_s    = 1'b1;
            cnt_clr_s = 1'b1;
            done_d    = 1'b1;
            periods_d = sat_inc(periods_q);
            state_d   = periodic_q ? ST_RUN : ST_IDLE;
          end else begin
            term_s = 1'b0;
          end
        end else begin
`ifdef COUNTER_SEQ_PRESCALE_EN
          div_d = div_q + PRESC_W'(1);
`endif
          tick_s = 1'b0;
        end
      end

      ST_PAUSE: begin
        // stop wins over start: abort clears the count, periods are kept
        if (stop) begin
          state_d   = ST_IDLE;
          cnt_clr_s = 1'b1;
        end else if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        cnt_clr_s = 1'b1;
      end
    endcase
  end

  // Controller state registers; clr overrides every command and terminal tick
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      limit_q    <= '0;
      periodic_q <= 1'b0;
      periods_q  <= '0;
      done_q     <= 1'b0;
`ifdef COUNTER_SEQ_PRESCALE_EN
      presc_q    <= '0;
      div_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      periods_q  <= periods_d;
      done_q     <= done_d;
`ifdef COUNTER_SEQ_PRESCALE_EN
      presc_q    <= presc_d;
      div_q      <= div_d;
`endif
    end
  end

  tff_chain_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .clr (cnt_clr_s),
    .T   (tick_s),
    .Q   (cnt_s)
  );

  assign count   = cnt_s;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign periods = periods_q;

endmodule : counter_seq_ctrl
